dmux_stream_sched: RTL and testbench

- Sequencing controller for the 1-to-N demultiplexer datapath. Accepts a single valid/ready input stream and steers each word to exactly one of N_OUT output channels.
- Destination is chosen round-robin or by an explicit select. Non-selected lanes are driven to zero, preserving DMux semantics.
- Uses a one-entry holding register (IDLE/HOLD FSM) so back-pressure from the chosen channel never corrupts data.
- Sits between a single producer and N consumer blocks.

---
 rtl/dmux_sched_pkg.sv | 26 ++
 rtl/dmux_lane_steer.sv | 35 +++
 rtl/dmux_stream_sched.sv | 150 +++++++++++++++
 tb/tb_dmux_stream_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_sched_pkg.sv
// Shared types and helpers for the dmux_stream_sched block.
//   state_e    : IDLE / HOLD state of the one-entry holding register
//   MODE_*     : encoding of the mode input
//   next_ptr() : round-robin wrap rule (n-1 -> 0, else +1)
//   wrap_idx() : folds an index in [0, 2n) back into [0, n)
package dmux_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Round-robin successor of ptr among n channels.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

  // An index held in clog2(n) bits is always below 2n, so one subtraction wraps it.
  function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/dmux_lane_steer.sv
// N-way demultiplexer lane steering (combinational).
// Decodes the held destination into a one-hot valid vector and places the
// held word on that lane only; every other lane is driven to zero.
//   i_active    : a word is held (HOLD state)
//   i_dest      : destination channel of the held word
//   i_data      : held word
//   o_valid_c   : one-hot channel valid, all-zero when not active
//   o_data_c    : flattened lanes, lane k = i_data when selected else 0
module dmux_lane_steer
  import dmux_sched_pkg::*;
#(
  parameter int unsigned N_OUT = 2,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PTR_W = 1
) (
  input  logic                   i_active,
  input  logic [PTR_W-1:0]       i_dest,
  input  logic [WIDTH-1:0]       i_data,
  output logic [N_OUT-1:0]       o_valid_c,
  output logic [N_OUT*WIDTH-1:0] o_data_c
);

  // One-hot decode plus lane zeroing.
  always_comb begin
    o_valid_c = '0;
    o_data_c  = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (i_active && (i_dest == PTR_W'(k))) begin
        o_valid_c[k]                = 1'b1;
        o_data_c[k*WIDTH +: WIDTH]  = i_data;
      end
    end
  end

endmodule

// File: rtl/dmux_stream_sched.sv
// Stream scheduler for a 1-to-N demultiplexer.
// Accepts one valid/ready stream and steers each word to exactly one of
// N_OUT channels, chosen round-robin (mode=0) or from sel (mode=1).
// A one-entry holding register (IDLE/HOLD) isolates the producer from
// consumer back-pressure; simultaneous drain and refill gives 1 word/clock.
// Optional: define DMUX_STREAM_SCHED_MASK_EN to add chan_en, which restricts
// round-robin selection to enabled channels.
//   clk, reset (sync, active-high)
//   mode, sel              : destination policy
//   in_valid/in_ready/in_data : producer stream
//   out_valid/out_ready/out_data : N consumer channels (flattened lanes)
//   chan_en                : round-robin eligibility (mask build only)
//   cur_dest               : held destination (HOLD) or RR pointer (IDLE)
//   busy                   : high in HOLD
module dmux_stream_sched
  import dmux_sched_pkg::*;
#(
  parameter  int unsigned N_OUT = 2,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic [PTR_W-1:0]       sel,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic [N_OUT-1:0]       out_valid,
  output logic [N_OUT*WIDTH-1:0] out_data,
  input  logic [N_OUT-1:0]       out_ready,
`ifdef DMUX_STREAM_SCHED_MASK_EN
  input  logic [N_OUT-1:0]       chan_en,
`endif
  output logic [PTR_W-1:0]       cur_dest,
  output logic                   busy
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_dest;
  logic [WIDTH-1:0]   r_data;
  logic               r_rr_word;

  logic               w_out_fire;
  logic               w_in_fire;
  logic [PTR_W-1:0]   w_rr_base;
  logic [PTR_W-1:0]   w_rr_pick;
  logic               w_rr_found;
  logic [PTR_W-1:0]   w_sel_wrap;
  logic [PTR_W-1:0]   w_new_dest;
  logic               w_accept_ok;
  logic               w_active;

  assign w_out_fire = (r_state == HOLD) && out_ready[r_dest];
  assign w_in_fire  = in_valid && in_ready;

  // The pointer a refill would see: already advanced if an RR word drains this cycle.
  assign w_rr_base = (w_out_fire && r_rr_word) ? PTR_W'(next_ptr(32'(r_dest), N_OUT))
                                               : r_rr_ptr;

`ifdef DMUX_STREAM_SCHED_MASK_EN
  // Circular search for the first enabled channel at or after w_rr_base.
  logic [PTR_W-1:0] w_idx;
  always_comb begin
    w_rr_pick  = w_rr_base;
    w_rr_found = 1'b0;
    w_idx      = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      w_idx = PTR_W'((32'(w_rr_base) + k) % N_OUT);
      if (!w_rr_found && chan_en[w_idx]) begin
        w_rr_pick  = w_idx;
        w_rr_found = 1'b1;
      end
    end
  end
`else
  assign w_rr_pick  = w_rr_base;
  assign w_rr_found = 1'b1;
`endif

  assign w_sel_wrap  = PTR_W'(wrap_idx(32'(sel), N_OUT));
  assign w_new_dest  = (mode == MODE_FIXED) ? w_sel_wrap : w_rr_pick;
  assign w_accept_ok = (mode == MODE_FIXED) || w_rr_found;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_in_fire) w_state_nxt = HOLD;
      HOLD:    if (w_out_fire && !w_in_fire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic; in_ready is a pass-through of the chosen consumer in HOLD.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    w_active = 1'b0;
    cur_dest = r_rr_ptr;
    unique case (r_state)
      IDLE: in_ready = !reset && w_accept_ok;
      HOLD: begin
        in_ready = !reset && out_ready[r_dest];
        busy     = 1'b1;
        w_active = 1'b1;
        cur_dest = r_dest;
      end
      default: ;
    endcase
  end

  // Holding register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr  <= '0;
      r_dest    <= '0;
      r_data    <= '0;
      r_rr_word <= 1'b0;
    end else begin
      if (w_out_fire && r_rr_word) r_rr_ptr <= PTR_W'(next_ptr(32'(r_dest), N_OUT));
      if (w_in_fire) begin
        r_data    <= in_data;
        r_dest    <= w_new_dest;
        r_rr_word <= (mode == MODE_RR);
      end
    end
  end

  dmux_lane_steer #(
    .N_OUT (N_OUT),
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) u_steer (
    .i_active  (w_active),
    .i_dest    (r_dest),
    .i_data    (r_data),
    .o_valid_c (out_valid),
    .o_data_c  (out_data)
  );

endmodule

// File: tb/tb_dmux_stream_sched.sv
// Bench for dmux_stream_sched: a 2-channel instance and a 3-channel
// (4-channel with DMUX_STREAM_SCHED_MASK_EN) instance, each checked every
// cycle against a transaction-level model, plus hand-computed literals.
module tb_dmux_stream_sched;

  localparam int unsigned NA = 2;
`ifdef DMUX_STREAM_SCHED_MASK_EN
  localparam int unsigned NB = 4;
`else
  localparam int unsigned NB = 3;
`endif
  localparam int unsigned WB = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            a_mode, a_in_valid, a_in_ready, a_busy;
  logic [0:0]      a_sel, a_cur_dest;
  logic [7:0]      a_in_data;
  logic [NA-1:0]   a_out_valid, a_out_ready;
  logic [NA*8-1:0] a_out_data;

  logic            b_mode, b_in_valid, b_in_ready, b_busy;
  logic [WB-1:0]   b_sel, b_cur_dest;
  logic [7:0]      b_in_data;
  logic [NB-1:0]   b_out_valid, b_out_ready;
  logic [NB*8-1:0] b_out_data;
`ifdef DMUX_STREAM_SCHED_MASK_EN
  logic [NA-1:0]   a_chan_en;
  logic [NB-1:0]   b_chan_en;
`endif

  dmux_stream_sched #(.N_OUT(NA), .WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .mode(a_mode), .sel(a_sel),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
`ifdef DMUX_STREAM_SCHED_MASK_EN
    .chan_en(a_chan_en),
`endif
    .cur_dest(a_cur_dest), .busy(a_busy)
  );

  dmux_stream_sched #(.N_OUT(NB), .WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .mode(b_mode), .sel(b_sel),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
`ifdef DMUX_STREAM_SCHED_MASK_EN
    .chan_en(b_chan_en),
`endif
    .cur_dest(b_cur_dest), .busy(b_busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending word (if any) with its channel, and the RR pointer.
  typedef struct {
    int unsigned hold;
    int unsigned dest;
    int unsigned data;
    int unsigned rr_word;
    int unsigned rr;
  } mdl_t;
  mdl_t m[2];

  function automatic int rr_pick(input int unsigned rr, input int unsigned n, input logic [31:0] en);
    for (int unsigned k = 0; k < n; k++) begin
      int unsigned c = (rr + k) % n;
      if (en[c]) return int'(c);
    end
    return -1;
  endfunction

  task automatic mdl_step(input int d, input string tag, input int unsigned n, input bit rst,
                          input bit mode, input int unsigned sel, input bit iv,
                          input int unsigned idata, input logic [31:0] ordy, input logic [31:0] en,
                          input logic [31:0] act_rdy, input logic [31:0] act_v,
                          input logic [31:0] act_d, input logic [31:0] act_cd,
                          input logic [31:0] act_busy);
    int pk;
    logic [31:0] ev, ed, er, ecd, eb;
    bit ofire, ifire;
    pk  = rr_pick(m[d].rr, n, en);
    ev  = (m[d].hold != 0) ? (32'd1 << m[d].dest) : 32'd0;
    ed  = (m[d].hold != 0) ? (m[d].data << (8 * m[d].dest)) : 32'd0;
    if (rst)                er = 32'd0;
    else if (m[d].hold != 0) er = 32'(ordy[m[d].dest]);
    else                    er = 32'(mode || (pk >= 0));
    ecd = (m[d].hold != 0) ? m[d].dest : m[d].rr;
    eb  = m[d].hold;
    check({tag, ".in_ready"},  act_rdy,  er);
    check({tag, ".out_valid"}, act_v,    ev);
    check({tag, ".out_data"},  act_d,    ed);
    check({tag, ".cur_dest"},  act_cd,   ecd);
    check({tag, ".busy"},      act_busy, eb);
    if (rst) begin
      m[d] = '{default: 0};
    end else begin
      ofire = (m[d].hold != 0) && ordy[m[d].dest];
      ifire = iv && er[0];
      if (ofire && (m[d].rr_word != 0)) m[d].rr = (m[d].dest + 1) % n;
      if (ifire) begin
        m[d].hold = 1;
        m[d].data = idata;
        if (mode) begin
          m[d].dest    = sel % n;
          m[d].rr_word = 0;
        end else begin
          pk           = rr_pick(m[d].rr, n, en);
          m[d].dest    = (pk >= 0) ? int'(pk) : m[d].rr;
          m[d].rr_word = 1;
        end
      end else if (ofire) begin
        m[d].hold = 0;
      end
    end
  endtask

  // Per-cycle compare on the falling edge, where inputs and outputs are settled.
  initial begin
    logic [31:0] en_a, en_b;
    m[0] = '{default: 0};
    m[1] = '{default: 0};
    forever begin
      @(negedge clk);
      if (chk_en) begin
`ifdef DMUX_STREAM_SCHED_MASK_EN
        en_a = 32'(a_chan_en);
        en_b = 32'(b_chan_en);
`else
        en_a = 32'hFFFF_FFFF;
        en_b = 32'hFFFF_FFFF;
`endif
        mdl_step(0, "a", NA, reset, a_mode, 32'(a_sel), a_in_valid, 32'(a_in_data),
                 32'(a_out_ready), en_a, 32'(a_in_ready), 32'(a_out_valid),
                 32'(a_out_data), 32'(a_cur_dest), 32'(a_busy));
        mdl_step(1, "b", NB, reset, b_mode, 32'(b_sel), b_in_valid, 32'(b_in_data),
                 32'(b_out_ready), en_b, 32'(b_in_ready), 32'(b_out_valid),
                 32'(b_out_data), 32'(b_cur_dest), 32'(b_busy));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef DMUX_STREAM_SCHED_MASK_EN
  localparam logic [31:0] SEL3_V = 32'h8, SEL3_D = 32'h3C00_0000;
  localparam logic [31:0] SEL2_V = 32'h4, SEL2_D = 32'h005A_0000;
`else
  localparam logic [31:0] SEL3_V = 32'h1, SEL3_D = 32'h0000_003C;
  localparam logic [31:0] SEL2_V = 32'h4, SEL2_D = 32'h005A_0000;
`endif

  initial begin
    a_mode = 1'b0; a_sel = '0; a_in_valid = 1'b1; a_in_data = 8'h11; a_out_ready = '1;
    b_mode = 1'b0; b_sel = '0; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = '1;
`ifdef DMUX_STREAM_SCHED_MASK_EN
    a_chan_en = '1;
    b_chan_en = '1;
`endif
    reset = 1'b1;

    // Reset held two cycles with in_valid high.
    tick();
    chk_en = 1'b1;
    check("rst1.in_ready", 32'(a_in_ready), 32'd0);
    check("rst1.out_valid", 32'(a_out_valid), 32'd0);
    tick();
    check("rst2.in_ready", 32'(a_in_ready), 32'd0);
    check("rst2.out_data", 32'(a_out_data), 32'd0);
    a_in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rel.in_ready", 32'(a_in_ready), 32'd1);
    check("rel.cur_dest", 32'(a_cur_dest), 32'd0);

    // Fixed destination with back-pressure; sel change during HOLD is ignored.
    a_mode = 1'b1; a_sel = 1'b1; a_out_ready = 2'b01; a_in_valid = 1'b1; a_in_data = 8'h55;
    tick();
    a_in_valid = 1'b0; a_sel = 1'b0;
    check("fix.out_valid", 32'(a_out_valid), 32'h2);
    check("fix.out_data", 32'(a_out_data), 32'h5500);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fix.stall_valid", 32'(a_out_valid), 32'h2);
      check("fix.stall_ready", 32'(a_in_ready), 32'd0);
    end
    a_out_ready = 2'b11;
    #1;
    check("fix.ready_pass", 32'(a_in_ready), 32'd1);
    tick();
    check("fix.drained", 32'(a_out_valid), 32'd0);
    check("fix.rr_kept", 32'(a_cur_dest), 32'd0);

    // Round-robin back-to-back, one word per clock.
    a_mode = 1'b0; a_in_valid = 1'b1; a_in_data = 8'hA1;
    tick();
    check("rr.v0", 32'(a_out_valid), 32'h1);
    check("rr.d0", 32'(a_out_data), 32'h00A1);
    check("rr.rdy0", 32'(a_in_ready), 32'd1);
    a_in_data = 8'hB2;
    tick();
    check("rr.v1", 32'(a_out_valid), 32'h2);
    check("rr.d1", 32'(a_out_data), 32'hB200);
    a_in_data = 8'hC3;
    tick();
    check("rr.v2", 32'(a_out_valid), 32'h1);
    check("rr.d2", 32'(a_out_data), 32'h00C3);
    a_in_valid = 1'b0;
    tick();
    check("rr.idle", 32'(a_out_valid), 32'd0);
    check("rr.ptr", 32'(a_cur_dest), 32'd1);

    // Reset while a word is pending: it is dropped.
    a_out_ready = 2'b00; a_in_valid = 1'b1; a_in_data = 8'h77;
    tick();
    a_in_valid = 1'b0;
    check("rmid.pend", 32'(a_out_valid), 32'h2);
    check("rmid.pdata", 32'(a_out_data), 32'h7700);
    reset = 1'b1;
    tick();
    check("rmid.valid", 32'(a_out_valid), 32'd0);
    check("rmid.data", 32'(a_out_data), 32'd0);
    check("rmid.busy", 32'(a_busy), 32'd0);
    reset = 1'b0; a_out_ready = 2'b11;
    tick();
    tick();
    check("rmid.lost", 32'(a_out_valid), 32'd0);
    check("rmid.ptr", 32'(a_cur_dest), 32'd0);

    // Out-of-range sel wraps modulo N; in-range sel is used directly.
    b_mode = 1'b1; b_sel = 2'd3; b_in_valid = 1'b1; b_in_data = 8'h3C;
    tick();
    check("wrap.valid", 32'(b_out_valid), SEL3_V);
    check("wrap.data", 32'(b_out_data), SEL3_D);
    b_sel = 2'd2; b_in_data = 8'h5A;
    tick();
    b_in_valid = 1'b0;
    check("sel2.valid", 32'(b_out_valid), SEL2_V);
    check("sel2.data", 32'(b_out_data), SEL2_D);
    tick();

`ifdef DMUX_STREAM_SCHED_MASK_EN
    // Masked round-robin over channels 1 and 3.
    b_mode = 1'b0; b_chan_en = 4'b1010; b_in_valid = 1'b1;
    b_in_data = 8'hD0; tick(); check("mask.w0", 32'(b_out_valid), 32'h2);
    b_in_data = 8'hD1; tick(); check("mask.w1", 32'(b_out_valid), 32'h8);
    b_in_data = 8'hD2; tick(); check("mask.w2", 32'(b_out_valid), 32'h2);
    b_in_data = 8'hD3; tick(); check("mask.w3", 32'(b_out_valid), 32'h8);
    check("mask.d3", 32'(b_out_data), 32'hD300_0000);
    b_in_valid = 1'b0;
    tick();
    b_chan_en = 4'b0000;
    #1;
    check("mask.none_rdy", 32'(b_in_ready), 32'd0);
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    check("mask.none_busy", 32'(b_busy), 32'd0);
    b_chan_en = 4'b1111;
    tick();
`else
    // Three-channel round-robin starting from pointer 0.
    b_mode = 1'b0; b_in_valid = 1'b1;
    b_in_data = 8'hE0; tick(); check("rr3.v0", 32'(b_out_valid), 32'h1);
    b_in_data = 8'hE1; tick(); check("rr3.v1", 32'(b_out_valid), 32'h2);
    b_in_data = 8'hE2; tick(); check("rr3.v2", 32'(b_out_valid), 32'h4);
    check("rr3.d2", 32'(b_out_data), 32'h00E2_0000);
    b_in_valid = 1'b0;
    tick();
    check("rr3.wrap", 32'(b_cur_dest), 32'd0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
